// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared constants and state type for dual_port_ram_param
package dual_port_ram_pkg;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int COLL_CNT_W = 16;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/dual_port_ram_if.sv
// dual_port_ram_if: control, port and status signals of dual_port_ram_param
interface dual_port_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  localparam int BE_W = DATA_W / 8;
  logic clr, ready, coll;
  logic en_a, en_b, we_a, we_b, vld_a, vld_b;
  logic [BE_W-1:0] be_a, be_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] din_a, din_b, dout_a, dout_b;
  logic [dual_port_ram_pkg::COLL_CNT_W-1:0] coll_cnt;
  modport master (
    output clr, en_a, en_b, we_a, we_b, be_a, be_b, addr_a, addr_b, din_a, din_b,
    input  ready, dout_a, dout_b, vld_a, vld_b, coll, coll_cnt
  );
  modport slave (
    input  clr, en_a, en_b, we_a, we_b, be_a, be_b, addr_a, addr_b, din_a, din_b,
    output ready, dout_a, dout_b, vld_a, vld_b, coll, coll_cnt
  );
endinterface

// File: rtl/dual_port_ram_port.sv
// dual_port_ram_port: per-port byte merge, read-during-write select and read pipeline
module dual_port_ram_port
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  act,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W-1:0]     old,
  output logic [DATA_W/8-1:0]   wbe,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     dout,
  output logic                  vld
);
  logic [DATA_W-1:0] rd_q;
  logic rv_q;
  assign wbe = be & {(DATA_W/8){act && we}};
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_byte
    assign wdata[8*i +: 8] = wbe[i] ? din[8*i +: 8] : old[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= act;
      if (act) rd_q <= RDW_MODE == RDW_WRITE_FIRST ? wdata : old;
    end
  if (OUT_REG != 0) begin : g_reg
    logic [DATA_W-1:0] d2_q;
    logic v2_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= rv_q;
        if (rv_q) d2_q <= rd_q;
      end
    assign dout = d2_q;
    assign vld = v2_q;
  end else begin : g_dir
    assign dout = rd_q;
    assign vld = rv_q;
  end
endmodule

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: true dual-port RAM with byte enables, clear sequencer and collision count
module dual_port_ram_param
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter int OUT_REG = 0
) (
  input logic clk,
  input logic rst_n,
  dual_port_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W = DATA_W / 8;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [BE_W-1:0] wbe_a, wbe_b;
  logic [DATA_W-1:0] wd_a, wd_b, cw;
  logic coll_nx;
  assign bus.ready = state == READY;
  dual_port_ram_port #(.DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_port_a (
    .clk, .rst_n, .act(bus.en_a && bus.ready), .we(bus.we_a), .be(bus.be_a), .din(bus.din_a),
    .old(mem[bus.addr_a]), .wbe(wbe_a), .wdata(wd_a), .dout(bus.dout_a), .vld(bus.vld_a)
  );
  dual_port_ram_port #(.DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_port_b (
    .clk, .rst_n, .act(bus.en_b && bus.ready), .we(bus.we_b), .be(bus.be_b), .din(bus.din_b),
    .old(mem[bus.addr_b]), .wbe(wbe_b), .wdata(wd_b), .dout(bus.dout_b), .vld(bus.vld_b)
  );
  assign coll_nx = |wbe_a && |wbe_b && bus.addr_a == bus.addr_b;
  // on collision A owns its enabled bytes; wd_b already holds B's bytes over the old word
  for (genvar i = 0; i < BE_W; i++) begin : g_coll
    assign cw[8*i +: 8] = wbe_a[i] ? wd_a[8*i +: 8] : wd_b[8*i +: 8];
  end
  always_comb state_nx = bus.clr ? CLEAR : (state == CLEAR && &ptr) ? READY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
      bus.coll <= 1'b0;
      bus.coll_cnt <= '0;
    end else begin
      state <= state_nx;
      ptr <= bus.clr ? '0 : state == CLEAR ? ptr + 1'b1 : ptr;
      bus.coll <= coll_nx;
      if (coll_nx && !(&bus.coll_cnt)) bus.coll_cnt <= bus.coll_cnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[ptr] <= '0;
    else begin
      if (|wbe_b) mem[bus.addr_b] <= wd_b;
      if (|wbe_a) mem[bus.addr_a] <= coll_nx ? cw : wd_a;
    end
endmodule

// File: tb/tb_dual_port_ram_param.sv
// tb_dual_port_ram_param: scoreboard bench driving a read-first/unregistered and a write-first/registered RAM
module tb_dual_port_ram_param;
  localparam int DW = 16, AW = 4, BW = 2, DEPTH = 16;
  typedef struct {logic [DW-1:0] d; int due;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dual_port_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  dual_port_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  dual_port_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  assign b1.clr = b0.clr;
  assign b1.en_a = b0.en_a;
  assign b1.en_b = b0.en_b;
  assign b1.we_a = b0.we_a;
  assign b1.we_b = b0.we_b;
  assign b1.be_a = b0.be_a;
  assign b1.be_b = b0.be_b;
  assign b1.addr_a = b0.addr_a;
  assign b1.addr_b = b0.addr_b;
  assign b1.din_a = b0.din_a;
  assign b1.din_b = b0.din_b;
  logic v [4];
  logic [DW-1:0] d [4];
  assign v[0] = b0.vld_a;
  assign v[1] = b0.vld_b;
  assign v[2] = b1.vld_a;
  assign v[3] = b1.vld_b;
  assign d[0] = b0.dout_a;
  assign d[1] = b0.dout_b;
  assign d[2] = b1.dout_a;
  assign d[3] = b1.dout_b;
  // queue k: 0/1 = u0 port a/b (old word, 1 cycle), 2/3 = u1 port a/b (merged word, 2 cycles)
  exp_t q [4][$];
  logic [DW-1:0] m [DEPTH];
  logic exp_ready = 1'b0, exp_coll = 1'b0;
  logic [15:0] exp_cnt = '0;
  int clear_left = DEPTH, cyc = 0, n_cmp = 0, n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) q[k].delete();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    exp_ready = 1'b0;
    exp_coll = 1'b0;
    exp_cnt = '0;
    clear_left = DEPTH;
  endtask

  task automatic step(input logic c, input logic ea, input logic wa, input logic [BW-1:0] ba,
                      input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic eb, input logic wb,
                      input logic [BW-1:0] bb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic [DW-1:0] oa, ob, na, nb;
    logic hit;
    b0.clr = c; b0.en_a = ea; b0.we_a = wa; b0.be_a = ba; b0.addr_a = aa; b0.din_a = da;
    b0.en_b = eb; b0.we_b = wb; b0.be_b = bb; b0.addr_b = ab; b0.din_b = db;
    hit = 1'b0;
    if (exp_ready) begin
      oa = m[aa];
      ob = m[ab];
      na = oa;
      nb = ob;
      for (int i = 0; i < BW; i++) begin
        if (ea && wa && ba[i]) na[8*i +: 8] = da[8*i +: 8];
        if (eb && wb && bb[i]) nb[8*i +: 8] = db[8*i +: 8];
      end
      if (ea) begin q[0].push_back('{oa, cyc + 1}); q[2].push_back('{na, cyc + 2}); end
      if (eb) begin q[1].push_back('{ob, cyc + 1}); q[3].push_back('{nb, cyc + 2}); end
      if (eb && wb) m[ab] = nb;
      for (int i = 0; i < BW; i++)
        if (ea && wa && ba[i]) m[aa][8*i +: 8] = da[8*i +: 8];
      hit = ea && wa && eb && wb && ba != 0 && bb != 0 && aa == ab;
    end
    @(posedge clk);
    exp_coll = hit;
    if (hit && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (c) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
    end else if (clear_left > 0) clear_left--;
    exp_ready = clear_left == 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    step(1'b0, 1'b1, 1'b0, '0, aa, '0, 1'b1, 1'b0, '0, ab, '0);
  endtask

  task automatic wr_a(input logic [AW-1:0] aa, input logic [DW-1:0] da, input logic [BW-1:0] ba);
    step(1'b0, 1'b1, 1'b1, ba, aa, da, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk)
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rst vld%0d", k), 32'(v[k]), 32'd0);
        chk($sformatf("rst dout%0d", k), 32'(d[k]), 32'd0);
      end
      chk("rst ready", 32'(b0.ready | b1.ready), 32'd0);
      chk("rst cnt", 32'(b0.coll_cnt | b1.coll_cnt), 32'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
          e = q[k].pop_front();
          chk($sformatf("vld%0d", k), 32'(v[k]), 32'd1);
          chk($sformatf("dout%0d", k), 32'(d[k]), 32'(e.d));
        end else if (v[k]) chk($sformatf("stray vld%0d", k), 32'(v[k]), 32'd0);
      end
      chk("ready0", 32'(b0.ready), 32'(exp_ready));
      chk("ready1", 32'(b1.ready), 32'(exp_ready));
      chk("coll0", 32'(b0.coll), 32'(exp_coll));
      chk("coll1", 32'(b1.coll), 32'(exp_coll));
      chk("cnt0", 32'(b0.coll_cnt), 32'(exp_cnt));
      chk("cnt1", 32'(b1.coll_cnt), 32'(exp_cnt));
    end

  initial begin
    b0.clr = 1'b0; b0.en_a = 1'b0; b0.we_a = 1'b0; b0.be_a = '0; b0.addr_a = '0; b0.din_a = '0;
    b0.en_b = 1'b0; b0.we_b = 1'b0; b0.be_b = '0; b0.addr_b = '0; b0.din_b = '0;
    model_reset();
    release_rst();
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));
    wr_a(4'd3, 16'h00A5, 2'b11);
    rd(4'd3, 4'd3);
    wr_a(4'd5, 16'h1234, 2'b11);
    wr_a(4'd5, 16'hABCD, 2'b01);
    rd(4'd5, 4'd5);
    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd7, 16'h0011, 1'b1, 1'b1, 2'b11, 4'd7, 16'h0022);
    rd(4'd7, 4'd7);
    step(1'b0, 1'b1, 1'b1, 2'b01, 4'd8, 16'h00AA, 1'b1, 1'b1, 2'b11, 4'd8, 16'hBBCC);
    step(1'b0, 1'b1, 1'b0, 2'b11, 4'd8, 16'h0000, 1'b1, 1'b1, 2'b10, 4'd8, 16'h5500);
    rd(4'd8, 4'd8);
    repeat (400)
      step(1'($urandom_range(49) == 0), 1'($urandom_range(3) != 0), 1'($urandom_range(1)), BW'($urandom),
           AW'($urandom_range(3)), DW'($urandom), 1'($urandom_range(3) != 0), 1'($urandom_range(1)),
           BW'($urandom), AW'($urandom_range(3)), DW'($urandom));
    idle(DEPTH + 2);
    wr_a(4'd9, 16'hCAFE, 2'b11);
    step(1'b1, 1'b1, 1'b1, 2'b11, 4'd10, 16'hBEEF, 1'b1, 1'b0, '0, 4'd9, '0);
    repeat (DEPTH)
      step(1'b0, 1'b1, 1'b1, 2'b11, AW'($urandom), DW'($urandom), 1'b1, 1'b0, '0, AW'($urandom), '0);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i));
    wr_a(4'd2, 16'h7777, 2'b11);
    rd(4'd2, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("async vld%0d", k), 32'(v[k]), 32'd0);
      chk($sformatf("async dout%0d", k), 32'(d[k]), 32'd0);
    end
    model_reset();
    release_rst();
    idle(DEPTH);
    rd(4'd2, 4'd3);
    repeat (65540) step(1'b0, 1'b1, 1'b1, '1, 4'd9, 16'h1111, 1'b1, 1'b1, '1, 4'd9, 16'h2222);
    rd(4'd9, 4'd9);
    idle(4);
    for (int k = 0; k < 4; k++) chk($sformatf("drain%0d", k), 32'(q[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_param.md
# dual_port_ram_param

Parametrised true dual-port synchronous RAM, the successor to the team's fixed 16x8 dual-port RAM. Adds configurable width and depth, byte-enable writes, a selectable same-port read-during-write mode, an optional output register with read-valid strobes, deterministic same-address write-collision resolution with a collision counter, and a hardware clear sequencer that zeroes the array after reset or on request. Used as the shared buffer between two independent masters in the same clock domain.

## Interface
- DATA_W, 8, word width in bits; a multiple of 8, at least 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- OUT_REG, 0, 1 adds an output pipeline register to both ports
- Derived: BE_W = DATA_W/8
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- clr  in  1  single-cycle request to re-zero the whole array
- ready  out  1  high when the ports accept accesses
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  1  write enable; qualified by en
- be_a / be_b  in  BE_W  byte enables for writes
- addr_a / addr_b  in  ADDR_W  word address
- din_a / din_b  in  DATA_W  write data
- dout_a / dout_b  out  DATA_W  read data
- vld_a / vld_b  out  1  dout holds data for a completed access
- coll  out  1  one-cycle pulse on a same-address write collision
- coll_cnt  out  16  saturating collision count

## Operation
- FSM states: CLEAR and READY. Reset puts the FSM in CLEAR with the clear pointer at 0.
- CLEAR: writes 0 to one word per cycle, pointer 0 to DEPTH-1. The FSM moves to READY after the write to DEPTH-1. ready=0 in this state. en_a and en_b are ignored: no writes, no reads, and vld stays 0.
- READY: ready=1. A clr pulse zeroes the pointer and the FSM enters CLEAR on the next cycle. Accesses presented in the same cycle as clr are still executed. A clr pulse during CLEAR restarts the pointer at 0.
- Access: en=1 and we=0 is a read. en=1 and we=1 is a write of the bytes with be set; bytes with be clear keep their old value. A write with be all-zero is a read.
- Same-port read-during-write: RDW_MODE=0 returns the old word. RDW_MODE=1 returns the merged new word.
- Cross-port read of an address the other port is writing in the same cycle always returns the old word.
- Collision: both ports write the same address in the same cycle.
  - Port A wins for every byte enabled on both ports.
  - Bytes enabled only on B take din_b.
  - coll pulses and coll_cnt increments by 1, saturating at 16'hFFFF.
  - Same-address reads, or one write plus one read, are not collisions.
- dout holds its value when en=0.

## Timing
- Reset values: ready=0, dout_a=dout_b=0, vld_a=vld_b=0, coll=0, coll_cnt=0, FSM=CLEAR, pointer=0.
- Read latency is 1+OUT_REG cycles from the en edge to dout.
- vld follows en with the same latency.
- Written data is visible to either port on an access issued one cycle after the write edge.
- ready rises on the edge after the write to DEPTH-1. With no clr, this is DEPTH cycles after rst_n deasserts.
- coll is asserted on the clock edge after the colliding cycle. coll_cnt updates on that same edge.
- rst_n asserted mid-operation: outputs return to reset values immediately. Array contents are undefined until the clear completes.

## Structure
- Package dual_port_ram_pkg holds:
  - RDW_READ_FIRST and RDW_WRITE_FIRST constants
  - the CLEAR/READY state enum
  - COLL_CNT_W = 16
- One sub-module, dual_port_ram_port, instantiated once per port. It contains the byte-merge logic, the RDW select, the optional output register and the vld pipeline.
- The top level contains the array, the clear FSM and the collision logic.

## Test plan
- Reset release with DATA_W=8 and ADDR_W=4 -> ready low for 16 cycles then high; a read of every address returns 8'h00.
- Port A writes 8'hA5 at address 3; port B reads address 3 one cycle later -> dout_b=8'hA5 and vld_b=1 after 1 cycle (2 cycles with OUT_REG=1).
- DATA_W=16: write 16'h1234, then write 16'hABCD with be=2'b01 -> read returns 16'h12CD. The same-port write cycle returns 16'h1234 with RDW_MODE=0 and 16'h12CD with RDW_MODE=1.
- Both ports write address 7: A writes 8'h11, B writes 8'h22, both be=1 -> address 7 reads 8'h11, one coll pulse, coll_cnt=1. Preload coll_cnt to 16'hFFFF and repeat -> coll_cnt stays 16'hFFFF.
- clr pulse after writes -> ready low for DEPTH cycles; accesses are ignored with vld=0; all addresses read 0 afterward.
- rst_n asserted while a read is in flight -> dout and vld go to 0 immediately and the clear sequence reruns.
